// File: rtl/fetch_stage_if.sv
// Instruction memory req/gnt/rvalid handshake bundle.
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemGnt,
        input  ImemRValid,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemGnt,
        output ImemRValid,
        output ImemRData
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC, single-outstanding fetch, hold buffer,
// redirects. Ports: CLK/RST_N, hazard stalls, D-stage redirect, imem bus,
// PCF, InstrD/PCPlus4D/ValidD to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               PCSrcD,
    input  logic               JumpD,
    input  logic [31:0]        PCBranchD,
    input  logic [31:0]        PCJumpD,
    fetch_stage_if.master      imem,
    output logic [31:0]        PCF,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pcf;
    logic [31:0] w_pcf_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_req;
    logic [31:0] w_pc_inc;
    logic        w_deliver;
    logic [31:0] w_ddata;

    // A stalled decode stage cannot act on its branch, so it is ignored.
    assign w_redir  = (JumpD | PCSrcD) & ~StallD;
    assign w_target = JumpD ? PCJumpD : PCBranchD;
    assign w_pc_inc = r_pcf + 32'd4;

    assign w_req = (r_state == S_REQ) & ~StallF & RST_N;

    assign imem.ImemReq  = w_req;
    assign imem.ImemAddr = r_pcf;

    assign PCF      = r_pcf;
    assign InstrD   = r_instr;
    assign PCPlus4D = r_pc4;
    assign ValidD   = r_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pcf_nxt   = r_pcf;
        w_hold_nxt  = r_hold;
        w_deliver   = 1'b0;
        w_ddata     = r_hold;

        unique case (r_state)
            S_REQ: begin
                if (w_req && imem.ImemGnt)
                    w_state_nxt = w_redir ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem.ImemRValid) begin
                    if (w_redir) begin
                        w_state_nxt = S_REQ;
                    end else if (StallD) begin
                        w_hold_nxt  = imem.ImemRData;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_deliver = 1'b1;
                        w_ddata   = imem.ImemRData;
                    end
                end else if (w_redir) begin
                    // response still owed by memory; swallow it later
                    w_state_nxt = S_DROP;
                end
            end
            S_HOLD: begin
                if (w_redir)
                    w_state_nxt = S_REQ;
                else if (!StallD)
                    w_deliver = 1'b1;
            end
            S_DROP: begin
                if (imem.ImemRValid)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase

        if (w_redir) begin
            w_pcf_nxt = w_target;
        end else if (w_deliver) begin
            w_pcf_nxt   = w_pc_inc;
            w_state_nxt = S_REQ;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_REQ;
            r_pcf   <= RESET_PC;
            r_hold  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pcf   <= w_pcf_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!StallD) begin
            if (w_deliver) begin
                r_instr <= w_ddata;
                r_pc4   <= w_pc_inc;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_pc4   <= 32'd0;
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level model.
// Memory responds 1..3 cycles after grant with random data.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        PCSrcD = 1'b0;
    logic        JumpD = 1'b0;
    logic [31:0] PCBranchD = '0;
    logic [31:0] PCJumpD = '0;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_stage_if imem ();

    fetch_stage #(
        .RESET_PC  (RPC),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .StallF    (StallF),
        .StallD    (StallD),
        .PCSrcD    (PCSrcD),
        .JumpD     (JumpD),
        .PCBranchD (PCBranchD),
        .PCJumpD   (PCJumpD),
        .imem      (imem.master),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Model: program counter, one fetch that may be in flight (and may
    // be known to be wrong-path), a parked response, and the IF/ID view.
    logic [31:0] m_pc;
    logic        m_inflight;
    logic        m_killed;
    logic        m_buf;
    logic [31:0] m_bufd;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    bit mem_busy;
    int mem_cnt;
    bit seen_req;

    task automatic model_reset();
        m_pc       = RPC;
        m_inflight = 1'b0;
        m_killed   = 1'b0;
        m_buf      = 1'b0;
        m_bufd     = '0;
        m_instr    = NOP;
        m_pc4      = '0;
        m_valid    = 1'b0;
    endtask

    function automatic logic m_req();
        return !m_inflight && !m_buf && !StallF && RST_N;
    endfunction

    task automatic model_step();
        logic        redir;
        logic        resp;
        logic        avail;
        logic        deliver;
        logic        granted;
        logic [31:0] tgt;
        logic [31:0] d;
        redir   = (JumpD || PCSrcD) && !StallD;
        tgt     = JumpD ? PCJumpD : PCBranchD;
        granted = m_req() && imem.ImemGnt;
        resp    = m_inflight && imem.ImemRValid;
        avail   = 1'b0;
        d       = '0;
        if (m_buf) begin
            avail = 1'b1;
            d     = m_bufd;
        end else if (resp && !m_killed) begin
            avail = 1'b1;
            d     = imem.ImemRData;
        end
        deliver = avail && !StallD && !redir;
        if (!StallD) begin
            if (deliver) begin
                m_instr = d;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
            end else begin
                m_instr = NOP;
                m_pc4   = '0;
                m_valid = 1'b0;
            end
        end
        if (resp && !m_killed && StallD) begin
            m_buf  = 1'b1;
            m_bufd = imem.ImemRData;
        end else if (!StallD) begin
            m_buf = 1'b0;
        end
        if (granted) begin
            m_inflight = 1'b1;
            m_killed   = redir;
        end else if (resp) begin
            m_inflight = 1'b0;
            m_killed   = 1'b0;
        end else if (m_inflight && redir) begin
            m_killed = 1'b1;
        end
        if (redir)
            m_pc = tgt;
        else if (deliver)
            m_pc = m_pc + 32'd4;
    endtask

    function automatic logic [31:0] rnd_target();
        int k;
        k = $urandom_range(0, 3);
        if (k == 0)
            return 32'hFFFF_FFFC;
        if (k == 1)
            return 32'hFFFF_FFF8;
        return $urandom & 32'h0000_FFFC;
    endfunction

    task automatic check_regs(input string sfx);
        chk({"PCF", sfx}, PCF, m_pc);
        chk({"InstrD", sfx}, InstrD, m_instr);
        chk({"PCPlus4D", sfx}, PCPlus4D, m_pc4);
        chk({"ValidD", sfx}, {31'd0, ValidD}, {31'd0, m_valid});
    endtask

    task automatic reset_seq();
        @(negedge CLK);
        StallF = 1'b0;
        StallD = 1'b0;
        JumpD  = 1'b0;
        PCSrcD = 1'b0;
        imem.ImemRValid = 1'b0;
        imem.ImemGnt = 1'b0;
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        mem_busy = 1'b0;
        check_regs("_rst");
        chk("ImemReq_rst", {31'd0, imem.ImemReq}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        imem.ImemGnt    = 1'b0;
        imem.ImemRValid = 1'b0;
        imem.ImemRData  = '0;
        model_reset();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        @(negedge CLK);
        #1;
        check_regs("_por");
        chk("ImemReq_por", {31'd0, imem.ImemReq}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if (i % 900 == 450) begin
                reset_seq();
            end
            @(negedge CLK);
            StallF = ($urandom_range(0, 9) < 2);
            StallD = ($urandom_range(0, 9) < 3);
            JumpD  = ($urandom_range(0, 15) == 0);
            PCSrcD = ($urandom_range(0, 15) == 0);
            PCJumpD   = rnd_target();
            PCBranchD = rnd_target();
            imem.ImemGnt    = ($urandom_range(0, 3) != 0);
            imem.ImemRValid = mem_busy && (mem_cnt == 0);
            imem.ImemRData  = $urandom;
            #1;
            chk("ImemReq", {31'd0, imem.ImemReq}, {31'd0, m_req()});
            chk("ImemAddr", imem.ImemAddr, m_pc);
            seen_req = imem.ImemReq;
            @(posedge CLK);
            #1;
            model_step();
            if (imem.ImemRValid)
                mem_busy = 1'b0;
            if (seen_req && imem.ImemGnt) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(0, 2);
            end else if (mem_busy && mem_cnt > 0) begin
                mem_cnt--;
            end
            check_regs("");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
